// File: rtl/mc_datapath_p_pkg.sv
// Shared encodings for the parametrised multicycle datapath: mux selects, ALU ops,
// immediate formats, multiplier FSM states and the reset instruction.
package mc_dp_pkg;

  typedef enum logic [1:0] {
    RES_ALUOUT = 2'd0,
    RES_MDR    = 2'd1,
    RES_ALU    = 2'd2,
    RES_MUL    = 2'd3
  } res_sel_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'd0,
    SRCA_OLDPC = 2'd1,
    SRCA_A     = 2'd2,
    SRCA_ZERO  = 2'd3
  } srca_sel_e;

  typedef enum logic [1:0] {
    SRCB_B    = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2,
    SRCB_ZERO = 2'd3
  } srcb_sel_e;

  typedef enum logic {
    ADDR_PC     = 1'b0,
    ADDR_ALUOUT = 1'b1
  } addr_sel_e;

  typedef enum logic [2:0] {
    EXT_I = 3'd0,
    EXT_S = 3'd1,
    EXT_B = 3'd2,
    EXT_J = 3'd3,
    EXT_U = 3'd4
  } ext_sel_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // 32-bit sign-extended immediate; caller widens to XLEN
  function automatic logic [31:0] imm32(input logic [31:0] ins, input logic [2:0] sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      EXT_I:   v = {{20{ins[31]}}, ins[31:20]};
      EXT_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      EXT_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      EXT_J:   v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      EXT_U:   v = {ins[31:12], 12'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mc_datapath_p_if.sv
// Memory-side bus of the multicycle datapath; master = datapath, slave = memory/controller side.
interface mc_datapath_p_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            mem_req;
  logic            mem_rvalid;
  logic [XLEN-1:0] read_data;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] write_data;
  logic            mem_stall;

  modport master (
    input  mem_req, mem_rvalid, read_data,
    output addr, write_data, mem_stall
  );

  modport slave (
    output mem_req, mem_rvalid, read_data,
    input  addr, write_data, mem_stall
  );
endinterface

// File: rtl/mc_datapath_p_mul.sv
// Iterative shift-add multiplier (XLEN iterations, low XLEN bits of product).
// Only instantiated when MC_DP_MUL_EN is defined.
module mc_dp_mul
  import mc_dp_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  mul_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0]  r_mcand, r_mplier, r_acc, r_result;
  logic [CNT_W-1:0] r_count;
  logic             w_load, w_step, w_busy, w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= MUL_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      MUL_IDLE: begin
        if (i_start) begin
          w_load      = 1'b1;
          w_state_nxt = MUL_RUN;
        end
      end
      MUL_RUN: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        if (r_count == CNT_W'(XLEN - 1)) w_state_nxt = MUL_DONE;
      end
      MUL_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = MUL_IDLE;
      end
      default: w_state_nxt = MUL_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      if (w_load) begin
        r_mcand  <= i_a;
        r_mplier <= i_b;
        r_acc    <= '0;
        r_count  <= '0;
      end else if (w_step) begin
        if (r_mplier[0]) r_acc <= r_acc + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + 1'b1;
      end
      if (w_done) r_result <= r_acc;
    end
  end

  assign o_busy   = w_busy;
  assign o_done   = w_done;
  assign o_result = r_result;

endmodule

// File: rtl/mc_datapath_p.sv
// Parametrised (XLEN) multicycle RISC-V datapath: PC/OldPC/IR/MDR/A/B/ALUOut, register file, ALU.
// Optional iterative multiplier built only when MC_DP_MUL_EN is defined.
module mc_datapath_p
  import mc_dp_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            sel_result,
  input  logic                  we_rf,
  input  logic [2:0]            sel_ext,
  input  logic [3:0]            alu_control,
  input  logic                  sel_mem_addr,
  input  logic [1:0]            sel_alu_src_a,
  input  logic [1:0]            sel_alu_src_b,
  input  logic                  we_ir,
  input  logic                  we_pc,
  input  logic                  mul_start,
  output logic                  zero,
  output logic [31:0]           instr,
  output logic                  mul_busy,
  output logic                  mul_done,
  mc_datapath_p_if.master       mem_bus
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [XLEN-1:0] r_pc, r_oldpc, r_mdr, r_a, r_b, r_aluout;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_rf [32];

  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rd1, w_rd2, w_imm, w_src_a, w_src_b, w_alu, w_result, w_mul_result;
  logic [31:0]     w_imm32;
  logic [SHW-1:0]  w_shamt;
  logic            w_mul_busy, w_mul_done;

  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];
  assign w_rd  = r_ir[11:7];

  // Not reset; x0 is never written and is forced to zero on read
  always_ff @(posedge clk) begin
    if (we_rf && (w_rd != 5'd0)) r_rf[w_rd] <= w_result;
  end

  assign w_rd1 = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
  assign w_rd2 = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];

  assign w_imm32 = imm32(r_ir, sel_ext);
  assign w_imm   = XLEN'($signed(w_imm32));

  always_comb begin
    w_src_a = '0;
    case (sel_alu_src_a)
      SRCA_PC:    w_src_a = r_pc;
      SRCA_OLDPC: w_src_a = r_oldpc;
      SRCA_A:     w_src_a = r_a;
      default:    w_src_a = '0;
    endcase
  end

  always_comb begin
    w_src_b = '0;
    case (sel_alu_src_b)
      SRCB_B:    w_src_b = r_b;
      SRCB_IMM:  w_src_b = w_imm;
      SRCB_FOUR: w_src_b = XLEN'(4);
      default:   w_src_b = '0;
    endcase
  end

  assign w_shamt = w_src_b[SHW-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_control)
      ALU_ADD:  w_alu = w_src_a + w_src_b;
      ALU_SUB:  w_alu = w_src_a - w_src_b;
      ALU_AND:  w_alu = w_src_a & w_src_b;
      ALU_OR:   w_alu = w_src_a | w_src_b;
      ALU_XOR:  w_alu = w_src_a ^ w_src_b;
      ALU_SLT:  w_alu = XLEN'($signed(w_src_a) < $signed(w_src_b));
      ALU_SLTU: w_alu = XLEN'(w_src_a < w_src_b);
      ALU_SLL:  w_alu = w_src_a << w_shamt;
      ALU_SRL:  w_alu = w_src_a >> w_shamt;
      ALU_SRA:  w_alu = $unsigned($signed(w_src_a) >>> w_shamt);
      default:  w_alu = '0;
    endcase
  end

  assign zero = (w_alu == '0);

  always_comb begin
    w_result = '0;
    case (sel_result)
      RES_ALUOUT: w_result = r_aluout;
      RES_MDR:    w_result = r_mdr;
      RES_ALU:    w_result = w_alu;
      default:    w_result = w_mul_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_oldpc  <= RESET_PC;
      r_ir     <= NOP_INSTR;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      if (we_pc) r_pc <= w_result;
      // A fetch request only completes when the memory returns data
      if (we_ir && mem_bus.mem_rvalid) begin
        r_ir    <= mem_bus.read_data[31:0];
        r_oldpc <= r_pc;
      end
      if (mem_bus.mem_rvalid) r_mdr <= mem_bus.read_data;
      r_a      <= w_rd1;
      r_b      <= w_rd2;
      r_aluout <= w_alu;
    end
  end

  assign instr              = r_ir;
  assign mem_bus.addr       = (sel_mem_addr == ADDR_ALUOUT) ? r_aluout : r_pc;
  assign mem_bus.write_data = r_b;
  assign mem_bus.mem_stall  = mem_bus.mem_req && !mem_bus.mem_rvalid;

`ifdef MC_DP_MUL_EN
  mc_dp_mul #(
    .XLEN(XLEN)
  ) u_mul (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_start  (mul_start),
    .i_a      (r_a),
    .i_b      (r_b),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_result (w_mul_result)
  );
`else
  logic w_unused_mul_start;
  assign w_unused_mul_start = mul_start;
  assign w_mul_busy         = 1'b0;
  assign w_mul_done         = 1'b0;
  assign w_mul_result       = '0;
`endif

  assign mul_busy = w_mul_busy;
  assign mul_done = w_mul_done;

endmodule

// File: tb/tb_mc_datapath_p.sv
// Scoreboard bench for mc_datapath_p: a cycle-level architectural model predicts every output,
// a separate monitor compares the DUT against the queued predictions.
module tb_mc_datapath_p;

  localparam int unsigned     XLEN = 32;
  localparam logic [XLEN-1:0] RPC  = 32'h100;
`ifdef MC_DP_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_result, sel_alu_src_a, sel_alu_src_b;
  logic        we_rf, sel_mem_addr, we_ir, we_pc, mul_start;
  logic [2:0]  sel_ext;
  logic [3:0]  alu_control;
  logic        zero, mul_busy, mul_done;
  logic [31:0] instr;

  mc_datapath_p_if #(.XLEN(XLEN)) bus ();

  mc_datapath_p #(
    .XLEN     (XLEN),
    .RESET_PC (RPC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sel_result    (sel_result),
    .we_rf         (we_rf),
    .sel_ext       (sel_ext),
    .alu_control   (alu_control),
    .sel_mem_addr  (sel_mem_addr),
    .sel_alu_src_a (sel_alu_src_a),
    .sel_alu_src_b (sel_alu_src_b),
    .we_ir         (we_ir),
    .we_pc         (we_pc),
    .mul_start     (mul_start),
    .zero          (zero),
    .instr         (instr),
    .mul_busy      (mul_busy),
    .mul_done      (mul_done),
    .mem_bus       (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst_n;
    logic [1:0]      sel_result, srca, srcb;
    logic            we_rf, sel_addr, we_ir, we_pc, mul_start, mem_req, mem_rvalid;
    logic [2:0]      sel_ext;
    logic [3:0]      alu;
    logic [XLEN-1:0] rdata;
  } in_t;

  typedef struct {
    int unsigned     cyc;
    logic [31:0]     instr;
    logic [XLEN-1:0] addr, wdata;
    logic            zero, stall, busy, done;
  } exp_t;

  exp_t        q[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;

  // Architectural model state
  logic [XLEN-1:0] m_rf[32];
  logic [XLEN-1:0] m_pc, m_oldpc, m_mdr, m_a, m_b, m_aluout, m_mulres, m_prod;
  logic [31:0]     m_ir;
  int unsigned     m_mul_left;   // cycles remaining until the multiplier is idle again

  task automatic m_reset();
    m_pc = RPC; m_oldpc = RPC; m_ir = 32'h0000_0013;
    m_mdr = '0; m_a = '0; m_b = '0; m_aluout = '0;
    m_mulres = '0; m_prod = '0; m_mul_left = 0;
  endtask

  function automatic logic [XLEN-1:0] m_imm(input logic [31:0] i, input logic [2:0] s);
    int v;
    case (s)
      3'd0: v = $signed(i) >>> 20;
      3'd1: v = (($signed(i) >>> 25) <<< 5) | int'(i[11:7]);
      3'd2: v = (($signed(i) >>> 31) <<< 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
      3'd3: v = (($signed(i) >>> 31) <<< 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
      3'd4: v = $signed(i & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] m_alu(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    int unsigned sh;
    sh = b % XLEN;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? XLEN'(1) : '0;
      4'd6: return (a < b) ? XLEN'(1) : '0;
      4'd7: return a << sh;
      4'd8: return a >> sh;
      4'd9: return $signed(a) >>> sh;
      default: return '0;
    endcase
  endfunction

  function automatic in_t idle_in();
    in_t c;
    c.rst_n = 1'b1; c.sel_result = 2'd0; c.srca = 2'd3; c.srcb = 2'd3;
    c.we_rf = 1'b0; c.sel_addr = 1'b0; c.we_ir = 1'b0; c.we_pc = 1'b0;
    c.mul_start = 1'b0; c.mem_req = 1'b0; c.mem_rvalid = 1'b0;
    c.sel_ext = 3'd0; c.alu = 4'd0; c.rdata = XLEN'($urandom);
    return c;
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
  endfunction

  // Drive one cycle, queue the predicted outputs, advance the model across the next edge
  task automatic step(input in_t c);
    exp_t e;
    logic [XLEN-1:0] sa, sb, alu, res, na, nb, pc0;
    logic [4:0] rs1, rs2, rd;
    @(negedge clk);
    rst = c.rst_n; sel_result = c.sel_result; we_rf = c.we_rf; sel_ext = c.sel_ext;
    alu_control = c.alu; sel_mem_addr = c.sel_addr; sel_alu_src_a = c.srca;
    sel_alu_src_b = c.srcb; we_ir = c.we_ir; we_pc = c.we_pc; mul_start = c.mul_start;
    bus.mem_req = c.mem_req; bus.mem_rvalid = c.mem_rvalid; bus.read_data = c.rdata;
    if (!c.rst_n) m_reset();
    rs1 = m_ir[19:15]; rs2 = m_ir[24:20]; rd = m_ir[11:7];
    case (c.srca) 2'd0: sa = m_pc; 2'd1: sa = m_oldpc; 2'd2: sa = m_a; default: sa = '0; endcase
    case (c.srcb) 2'd0: sb = m_b; 2'd1: sb = m_imm(m_ir, c.sel_ext); 2'd2: sb = XLEN'(4); default: sb = '0; endcase
    alu = m_alu(c.alu, sa, sb);
    case (c.sel_result) 2'd0: res = m_aluout; 2'd1: res = m_mdr; 2'd2: res = alu; default: res = m_mulres; endcase
    e.cyc = cyc; e.instr = m_ir; e.addr = c.sel_addr ? m_aluout : m_pc; e.wdata = m_b;
    e.zero = (alu == '0); e.stall = c.mem_req && !c.mem_rvalid;
    e.busy = (m_mul_left > 0); e.done = (m_mul_left == 1);
    q.push_back(e);
    cyc++;
    na = (rs1 == 5'd0) ? '0 : m_rf[rs1];
    nb = (rs2 == 5'd0) ? '0 : m_rf[rs2];
    if (c.we_rf && rd != 5'd0) m_rf[rd] = res;
    if (c.rst_n) begin
      pc0 = m_pc;
      if (MUL_ON) begin
        if (m_mul_left == 1) m_mulres = m_prod;
        if (m_mul_left > 0) m_mul_left--;
        else if (c.mul_start) begin
          m_prod = m_a * m_b;
          m_mul_left = XLEN + 1;
        end
      end
      if (c.we_pc) m_pc = res;
      if (c.we_ir && c.mem_rvalid) begin m_ir = c.rdata[31:0]; m_oldpc = pc0; end
      if (c.mem_rvalid) m_mdr = c.rdata;
      m_a = na; m_b = nb; m_aluout = alu;
    end
  endtask

  task automatic write_reg(input logic [4:0] idx, input logic [XLEN-1:0] val);
    in_t c;
    c = idle_in(); c.we_ir = 1'b1; c.mem_rvalid = 1'b1; c.rdata = XLEN'(mk_instr(5'd0, 5'd0, idx)); step(c);
    c = idle_in(); c.mem_rvalid = 1'b1; c.rdata = val; step(c);
    c = idle_in(); c.we_rf = 1'b1; c.sel_result = 2'd1; step(c);
  endtask

  task automatic load_ir(input logic [4:0] rs1, input logic [4:0] rs2);
    in_t c;
    c = idle_in(); c.we_ir = 1'b1; c.mem_req = 1'b1; c.mem_rvalid = 1'b1;
    c.rdata = XLEN'(mk_instr(rs2, rs1, 5'd0)); step(c);
  endtask

  task automatic start_mul();
    in_t c;
    c = idle_in(); c.mul_start = 1'b1; step(c);
  endtask

  // PC <- multiplier result, then present PC on addr
  task automatic read_mul();
    in_t c;
    c = idle_in(); c.we_pc = 1'b1; c.sel_result = 2'd3; step(c);
    step(idle_in());
  endtask

  task automatic chk(input string nm, input int unsigned cy, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cy, act, exp);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("instr",      e.cyc, 64'(instr),          64'(e.instr));
        chk("addr",       e.cyc, 64'(bus.addr),       64'(e.addr));
        chk("write_data", e.cyc, 64'(bus.write_data), 64'(e.wdata));
        chk("zero",       e.cyc, 64'(zero),           64'(e.zero));
        chk("mem_stall",  e.cyc, 64'(bus.mem_stall),  64'(e.stall));
        chk("mul_busy",   e.cyc, 64'(mul_busy),       64'(e.busy));
        chk("mul_done",   e.cyc, 64'(mul_done),       64'(e.done));
      end
    end
  end

  initial begin : driver
    in_t c;
    rst = 1'b0; sel_result = '0; we_rf = 1'b0; sel_ext = '0; alu_control = '0;
    sel_mem_addr = 1'b0; sel_alu_src_a = 2'd3; sel_alu_src_b = 2'd3; we_ir = 1'b0;
    we_pc = 1'b0; mul_start = 1'b0; bus.mem_req = 1'b0; bus.mem_rvalid = 1'b0;
    bus.read_data = '0;
    for (int unsigned i = 0; i < 32; i++) m_rf[i] = '0;
    m_reset();

    c = idle_in(); c.rst_n = 1'b0;
    step(c); step(c);
    step(idle_in());

    for (int unsigned i = 1; i < 32; i++) write_reg(5'(i), XLEN'($urandom));

    // Fetch stalled three cycles before data arrives
    for (int unsigned i = 0; i < 4; i++) begin
      c = idle_in(); c.we_ir = 1'b1; c.mem_req = 1'b1; c.mem_rvalid = (i == 3);
      c.rdata = (i == 3) ? XLEN'(32'h0050_0093) : XLEN'($urandom);
      step(c);
    end
    step(idle_in());

    // 7 x 6, with a restart attempt and an operand change mid-run
    write_reg(5'd1, XLEN'(7)); write_reg(5'd2, XLEN'(6));
    load_ir(5'd1, 5'd2); step(idle_in());
    start_mul();
    step(idle_in()); start_mul(); load_ir(5'd3, 5'd4);
    for (int unsigned i = 0; i < XLEN; i++) step(idle_in());
    read_mul();

    // 0xFFFFFFFF x 2, started as soon as the previous one finished
    write_reg(5'd5, '1); write_reg(5'd6, XLEN'(2));
    load_ir(5'd5, 5'd6); step(idle_in());
    start_mul();
    for (int unsigned i = 0; i < XLEN + 1; i++) step(idle_in());
    start_mul();
    for (int unsigned i = 0; i < XLEN + 2; i++) step(idle_in());
    read_mul();

    // Reset in the middle of a run, then a clean multiply
    load_ir(5'd1, 5'd2); step(idle_in());
    start_mul();
    for (int unsigned i = 0; i < 10; i++) step(idle_in());
    c = idle_in(); c.rst_n = 1'b0; step(c); step(c);
    load_ir(5'd1, 5'd2); step(idle_in());
    start_mul();
    for (int unsigned i = 0; i < XLEN + 2; i++) step(idle_in());
    read_mul();

    // Writes to x0 are discarded
    write_reg(5'd0, XLEN'(32'hDEAD));
    load_ir(5'd0, 5'd0); step(idle_in());
    c = idle_in(); c.srca = 2'd2; c.srcb = 2'd0; step(c);

    for (int unsigned i = 0; i < 600; i++) begin
      c = idle_in();
      c.rst_n      = ($urandom_range(79) != 0);
      c.sel_result = 2'($urandom_range(3));
      c.srca       = 2'($urandom_range(3));
      c.srcb       = 2'($urandom_range(3));
      c.we_rf      = 1'($urandom_range(1));
      c.sel_addr   = 1'($urandom_range(1));
      c.we_ir      = 1'($urandom_range(1));
      c.we_pc      = 1'($urandom_range(1));
      c.mul_start  = ($urandom_range(7) == 0);
      c.mem_req    = 1'($urandom_range(1));
      c.mem_rvalid = 1'($urandom_range(1));
      c.sel_ext    = 3'($urandom_range(7));
      c.alu        = 4'($urandom_range(15));
      step(c);
    end

    repeat (2) @(negedge clk);
    #4;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_datapath_p.md
# mc_datapath_p

Parametrised multicycle RISC-V datapath: successor to the fixed 32-bit multicycle datapath, generalised to XLEN, with a valid-qualified memory read interface and an optional iterative shift-add multiplier. Sits between the multicycle controller (which drives all selects and enables) and the unified instruction/data memory. Holds PC, OldPC, IR, MDR, A, B and ALUOut, plus the multiplier state.

## Interface
- XLEN, 32: datapath width (32 or 64); instructions stay 32 bits.
- RESET_PC, 0: PC and OldPC value after reset (XLEN bits).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- sel_result  in  2  result mux: 0 ALUOut, 1 MDR, 2 ALU result, 3 multiplier result.
- we_rf  in  1  register-file write enable.
- sel_ext  in  3  immediate format select; sign-extended to XLEN.
- alu_control  in  4  ALU operation.
- sel_mem_addr  in  1  memory address: 0 PC, 1 ALUOut.
- sel_alu_src_a  in  2  0 PC, 1 OldPC, 2 A, 3 zero.
- sel_alu_src_b  in  2  0 B, 1 ImmExt, 2 constant 4, 3 zero.
- we_ir, we_pc  in  1 each  IR/OldPC capture request; PC write enable.
- mem_req  in  1  controller is waiting on a memory read this cycle.
- mem_rvalid  in  1  read_data is valid this cycle.
- read_data  in  XLEN  memory read data.
- mul_start  in  1  start multiply of A×B.
- zero  out  1  ALU result equals 0.
- instr  out  32  IR contents.
- addr  out  XLEN  memory address.
- write_data  out  XLEN  B register.
- mem_stall  out  1  mem_req && !mem_rvalid (combinational).
- mul_busy, mul_done  out  1 each  multiplier running; one-cycle completion pulse.

## Operation
- PC: loads result when we_pc. IR and OldPC load read_data[31:0] and PC only when we_ir && mem_rvalid; we_ir without mem_rvalid holds both.
- MDR loads read_data only when mem_rvalid; otherwise holds. A, B, ALUOut load every cycle.
- Register file: 32×XLEN, x0 reads 0, writes to x0 discarded; write on rising edge when we_rf; read combinational (write-then-read same cycle returns old value).
- Multiplier FSM: IDLE → RUN on mul_start (latch A as multiplicand, B as multiplier, clear accumulator, count=0). RUN: per cycle, if multiplier LSB add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; count++. After XLEN iterations → DONE. DONE: mul_done=1 one cycle, result register loaded with low XLEN bits of product, → IDLE.
- mul_busy=1 in RUN and DONE. mul_start while busy is ignored. mul_start in DONE cycle ignored; accepted next cycle.
- Product arithmetic: unsigned modulo 2^XLEN (equals low half of signed product).
- Multiplier result holds until next DONE; sel_result=3 reads it any time.

## Timing
- Reset (rst=0, async): PC=OldPC=RESET_PC, IR=32'h00000013, MDR=A=B=ALUOut=0, mul result 0, FSM IDLE, mul_busy=mul_done=0. Register file contents not reset.
- Reset asserted mid-multiply aborts immediately to IDLE; no mul_done issued.
- mem_stall combinational, same cycle as mem_req; zero combinational from ALU.
- Multiply latency: mul_start sampled at edge 0 → mul_done high in cycle XLEN+1 → result valid from edge XLEN+2; back-to-back start earliest cycle XLEN+2.
- A/B change during RUN does not affect the in-flight product.

## Configuration
- MC_DP_MUL_EN defined: multiplier and FSM built as above.
- Not defined: no multiplier logic; mul_start ignored; mul_busy=mul_done=0; sel_result=3 yields 0.

## Structure
- Package mc_dp_pkg: result-select, src-A, src-B and address-select encodings; multiplier state enum (IDLE, RUN, DONE); NOP encoding constant.
- One sub-module: mc_dp_mul (FSM, counter, accumulator), instantiated under MC_DP_MUL_EN.

## Test plan
- Reset with RESET_PC=32'h100 -> PC=OldPC=0x100, IR=0x00000013, all outputs idle; release, addr=0x100.
- we_ir=1, mem_req=1, mem_rvalid=0 for 3 cycles then 1 with read_data=0x00500093 -> mem_stall high 3 cycles, IR updates only on 4th edge, OldPC=PC.
- A=7, B=6, mul_start -> mul_done pulse in cycle 33 (XLEN=32), sel_result=3 gives 42; A=0xFFFFFFFF, B=2 -> 0xFFFFFFFE.
- mul_start repeated while busy and A changed mid-run -> single done, product of original operands.
- rst low at RUN cycle 10 -> IDLE immediately, no mul_done; next start completes normally.
- XLEN=64 build, we_rf to x0 with 0xDEAD -> x0 reads 0; macro undefined -> sel_result=3 yields 0, mul_busy stays 0.
